// File: rtl/exp_share_arbiter_pkg.sv
// Shared types for the exp-unit sharing arbiter.
// Operand/result widths, requester state and issue tag.
package exp_share_pkg;

  localparam int OP_W  = 12;
  localparam int RES_W = 20;
  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } req_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/exp_share_arbiter_if.sv
// Requester, response and shared-unit signal bundle.
// slave = arbiter side, master = requesters plus exp unit.
interface exp_share_arbiter_if
  import exp_share_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][OP_W-1:0]  req_data;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0]            rsp_valid;
  logic [N_REQ-1:0][RES_W-1:0] rsp_data;
  logic [N_REQ-1:0]            rsp_ready;
  logic                        exp_valid;
  logic [OP_W-1:0]             exp_data;
  logic                        exp_result_valid;
  logic [RES_W-1:0]            exp_result;
  logic                        err;

  modport slave (
    input  req_valid, req_data, rsp_ready,
    input  exp_result_valid, exp_result,
    output req_ready, rsp_valid, rsp_data,
    output exp_valid, exp_data, err
  );

  modport master (
    output req_valid, req_data, rsp_ready,
    output exp_result_valid, exp_result,
    input  req_ready, rsp_valid, rsp_data,
    input  exp_valid, exp_data, err
  );

endinterface

// File: rtl/exp_share_arbiter_rr_arbiter.sv
// N-way round-robin grant over a request mask.
// Search starts at ptr; ptr moves past each winner.
module rr_arbiter
  import exp_share_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grantIdx,
  output logic             anyGrant
);

  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     rot;

  // Rotate requests so bit 0 is the pointer position, pick first set
  always_comb begin
    int j;
    j        = 0;
    anyGrant = 1'b0;
    grantIdx = '0;
    rot      = N'({req, req} >> ptr);
    for (int k = 0; k < N; k++) begin
      if (!anyGrant && rot[k]) begin
        anyGrant = 1'b1;
        j        = int'(ptr) + k;
        if (j >= N) j = j - N;
        grantIdx = IDX_W'(j);
      end
    end
  end

  // Expand the winning index to a one-hot grant
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = anyGrant && (grantIdx == IDX_W'(i));
    end
  end

  // Pointer advances to winner+1, wrapping at N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (anyGrant) begin
      ptr <= (grantIdx == IDX_W'(N - 1)) ? '0
           : grantIdx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/exp_share_arbiter.sv
// Shares one fixed-latency exp unit among N_REQ requesters.
// Per-requester FSM, RR issue, tag pipe routes results back.
module exp_share_arbiter
  import exp_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int EXP_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  exp_share_arbiter_if.slave bus
);

  req_state_e state    [N_REQ];
  req_state_e stateNxt [N_REQ];

  logic [N_REQ-1:0] idleMask;
  logic [N_REQ-1:0] reqMask;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] cap;
  logic [IDX_W-1:0] grantIdx;
  logic             anyGrant;
  logic [OP_W-1:0]  grantData;

  logic             expValid;
  logic [OP_W-1:0]  expData;
  logic [IDX_W-1:0] issueIdx;

  tag_t tagPipe [EXP_LAT];
  tag_t tagOut;

  logic [N_REQ-1:0][RES_W-1:0] rspData;
  logic                        errQ;

  assign reqMask = bus.req_valid & idleMask;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (reqMask),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

  // Ready is the grant itself, forced low while in reset
  assign bus.req_ready = rst_n ? grant : '0;

  // Select the winning operand
  always_comb begin
    grantData = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grantData = grantData | bus.req_data[i];
    end
  end

  // Registered issue to the shared unit; data holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expValid <= 1'b0;
      expData  <= '0;
      issueIdx <= '0;
    end else begin
      expValid <= anyGrant;
      if (anyGrant) begin
        expData  <= grantData;
        issueIdx <= grantIdx;
      end
    end
  end

  // Tag pipe tracks which requester owns each in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < EXP_LAT; k++) tagPipe[k] <= '0;
    end else begin
      tagPipe[0] <= '{valid: expValid, idx: issueIdx};
      for (int k = 1; k < EXP_LAT; k++) begin
        tagPipe[k] <= tagPipe[k-1];
      end
    end
  end

  assign tagOut = tagPipe[EXP_LAT-1];

  // Idle flags and per-requester capture strobes from the tag
  always_comb begin
    idleMask = '0;
    cap      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idleMask[i] = (state[i] == IDLE);
      cap[i]      = tagOut.valid
                 && (tagOut.idx == IDX_W'(i));
    end
  end

  // Requester FSM next state
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stateNxt[i] = state[i];
      unique case (state[i])
        IDLE: if (grant[i])            stateNxt[i] = BUSY;
        BUSY: if (cap[i])              stateNxt[i] = DONE;
        DONE: if (bus.rsp_ready[i])    stateNxt[i] = IDLE;
        default:                       stateNxt[i] = IDLE;
      endcase
    end
  end

  // Requester FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) state[i] <= IDLE;
    end else begin
      for (int i = 0; i < N_REQ; i++) state[i] <= stateNxt[i];
    end
  end

  // Result capture follows the tag, never the unit strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspData <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cap[i]) rspData[i] <= bus.exp_result;
      end
    end
  end

  // Response valid is simply the DONE state
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.rsp_valid[i] = (state[i] == DONE);
    end
  end

  // Sticky error when unit strobe disagrees with the tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errQ <= 1'b0;
    end else if (bus.exp_result_valid != tagOut.valid) begin
      errQ <= 1'b1;
    end
  end

  assign bus.rsp_data  = rspData;
  assign bus.exp_valid = expValid;
  assign bus.exp_data  = expData;
  assign bus.err       = errQ;

endmodule
